cannon_sequencer: RTL
=====================

// Module: cannon_sequencer
// PURPOSE
//  Top-level scheduler for the N x N message_passer array running Cannon's matrix multiply.
//  Steps the array through: load, clear accumulators, skew, then N multiply/rotate rounds.
//  Drives one array-wide command per step and completes a ready/ack handshake for each.
//  Per-row and per-column masks let one command act on a subset of the array.
// PARAMETERS
//  N        4      array dimension (rows = cols); N >= 2
//  TIMEOUT  255    max cycles to wait for ready_all before error; 8-bit watchdog counter
// PORTS
//  CLK          in   1        single clock, all state on posedge
//  reset_n      in   1        synchronous, active-low reset
//  start        in   1        begin a run; sampled only in IDLE
//  abort        in   1        terminate current run after current handshake closes
//  ready_all    in   1        AND of every enabled passer's ready
//  cmd          out  3        command code to array (encodings in pe_defs.vh)
//  cmd_valid    out  1        array executes cmd only while high
//  image_to_shift out 1       0 = shift A, 1 = shift B
//  ack          out  1        one-cycle acknowledge to array
//  row_en       out  N        per-row enable, bit i = row i
//  col_en       out  N        per-column enable, bit j = column j
//  s_zero       out  1        high during CLEAR; array muxes 0 onto s_out_overwrite
//  busy         out  1        high from start accept until return to IDLE
//  done         out  1        one-cycle pulse on successful completion
//  error        out  1        sticky watchdog flag; cleared by next accepted start
//  round        out  $clog2(N+1)  multiply rounds completed in current run
// BEHAVIOUR
//  Reset: all outputs 0; row_en = col_en = 0; FSM in IDLE; counters 0.
//  Handshake per command, three phases:
//   - ISSUE: cmd_valid = 1, cmd/masks stable; wait for ready_all = 1.
//   - ACK: cmd_valid = 0, ack = 1 for exactly one cycle.
//   - DRAIN: wait for ready_all = 0, then go to the next command.
//   - Latency: minimum 3 cycles per command.
//  Watchdog:
//   - Counts cycles in ISSUE and in DRAIN; reloads on every phase change.
//   - When the count reaches TIMEOUT: error = 1, one ack pulse, then IDLE. No done.
//  Command sequence (skew shifts are A-left and B-up):
//   - LOAD: 101, all masks 1.
//   - CLEAR: 110, s_zero = 1.
//   - SKEW k = 1..N-1: shift-left A (011, image 0) with row_en[i] = (i >= k),
//     then shift-up B (001, image 1) with col_en[j] = (j >= k).
//   - ROUND r = 0..N-1: multiply (000), round++; if r < N-1, shift-left A then shift-up B, all masks 1.
//   - DONE: done pulse, busy = 0, return to IDLE.
//   - Total commands = 5N-2, i.e. 18 for N = 4.
//  Masks for commands that are not row/column specific are all 1.
//   - Shift-left uses row_en with col_en all 1; shift-up uses col_en with row_en all 1.
//  start while busy: ignored. start and abort in the same IDLE cycle: abort wins, no run.
//  abort in ISSUE: one ack pulse, then IDLE. abort in ACK/DRAIN: finish the handshake, then IDLE.
//   - Either way: no done, error unchanged.
//  reset_n low mid-run: next posedge forces reset values. ack is not held.
//  round saturates at N. It is cleared when start is accepted.
// STRUCTURE
//  pe_defs.vh (shared include):
//   - CMD_MULT / CMD_UP / CMD_DOWN / CMD_LEFT / CMD_RIGHT / CMD_LOADAB / CMD_LOADS / CMD_RST.
//   - Sequencer state encodings: IDLE, LOAD, CLEAR, SKEW, ROUND, DONE.
//  Sub-module cmd_handshake:
//   - Owns the ISSUE/ACK/DRAIN phases and the watchdog.
//   - Gets go/abort from the sequencer; returns cmd_done/timeout.
//  Top level holds the phase FSM, the skew counter k, the round counter r and mask generation.
// TESTING
//  N=4, ready_all responder with 1-cycle latency, pulse start
//   -> exactly 18 commands in the specified order; done pulses once; round = 4.
//  Skew check, N=4
//   -> k=1 row_en = 4'b1110, k=2 4'b1100, k=3 4'b1000; col_en follows the same pattern.
//  Responder never raises ready_all, TIMEOUT = 10
//   -> error = 1 about 11 cycles after the LOAD issue; one ack pulse; IDLE; done never high.
//  abort during round-2 multiply ISSUE
//   -> one ack pulse, busy falls, no done, round = 1.
//  reset_n low for 1 cycle during SKEW
//   -> every output at its reset value on the next edge; a new start runs the full sequence.
//  start pulses while busy
//   -> ignored; still exactly 18 commands per run.

Source files
------------

// File: rtl/cannon_sequencer_pkg.sv
// Shared definitions for the Cannon matrix-multiply sequencer.
//   - Array command codes driven on cmd.
//   - Sequencer step encodings and handshake phase encodings.
package cannon_sequencer_pkg;

    localparam logic [2:0] CMD_MULT   = 3'b000;
    localparam logic [2:0] CMD_UP     = 3'b001;
    localparam logic [2:0] CMD_DOWN   = 3'b010;
    localparam logic [2:0] CMD_LEFT   = 3'b011;
    localparam logic [2:0] CMD_RIGHT  = 3'b100;
    localparam logic [2:0] CMD_LOADAB = 3'b101;
    localparam logic [2:0] CMD_LOADS  = 3'b110;
    localparam logic [2:0] CMD_RST    = 3'b111;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_CLEAR,
        SEQ_SKEW,
        SEQ_ROUND,
        SEQ_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_ISSUE,
        PH_ACK,
        PH_DRAIN
    } hs_phase_t;

endpackage

// File: rtl/cannon_sequencer_cmd_handshake.sv
// Three-phase ready/ack handshake for one array command, with watchdog.
// Ports:
//   CLK, reset_n   clock, synchronous active-low reset
//   go             launch a command (from idle, or on the cycle cmd_done fires)
//   abort          give up while waiting in ISSUE
//   ready_all      combined ready from the array
//   cmd_valid      high in ISSUE
//   ack            high in ACK (one cycle per pass through ACK)
//   cmd_done       pulse: handshake closed normally (ready_all fell in DRAIN)
//   cmd_fail       pulse: ACK of an aborted or timed-out handshake; phase returns idle
//   timeout        pulse: watchdog hit its terminal count
//
// phase    | meaning
// PH_IDLE  | no command in flight
// PH_ISSUE | cmd_valid high, waiting for ready_all
// PH_ACK   | one-cycle acknowledge
// PH_DRAIN | waiting for ready_all to fall
module cmd_handshake
    import cannon_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic go,
    input  logic abort,
    input  logic ready_all,
    output logic cmd_valid,
    output logic ack,
    output logic cmd_done,
    output logic cmd_fail,
    output logic timeout
);

    localparam logic [7:0] WD_LOAD = 8'(TIMEOUT);

    hs_phase_t  phase, phase_nxt;
    logic [7:0] wd, wd_nxt;
    logic       fail_q, fail_nxt;

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            phase  <= PH_IDLE;
            wd     <= '0;
            fail_q <= 1'b0;
        end else begin
            phase  <= phase_nxt;
            wd     <= wd_nxt;
            fail_q <= fail_nxt;
        end
    end

    // Watchdog is a down-counter reloaded on every phase entry; reaching zero
    // while still waiting takes the abnormal ACK path.
    always_comb begin
        phase_nxt = phase;
        wd_nxt    = wd;
        fail_nxt  = fail_q;
        cmd_valid = 1'b0;
        ack       = 1'b0;
        cmd_done  = 1'b0;
        cmd_fail  = 1'b0;
        timeout   = 1'b0;
        case (phase)
            PH_IDLE: begin
                if (go) begin
                    phase_nxt = PH_ISSUE;
                    wd_nxt    = WD_LOAD;
                end
            end
            PH_ISSUE: begin
                cmd_valid = 1'b1;
                if (abort) begin
                    phase_nxt = PH_ACK;
                    fail_nxt  = 1'b1;
                end else if (ready_all) begin
                    phase_nxt = PH_ACK;
                    fail_nxt  = 1'b0;
                end else if (wd == 8'd0) begin
                    phase_nxt = PH_ACK;
                    fail_nxt  = 1'b1;
                    timeout   = 1'b1;
                end else begin
                    wd_nxt = wd - 8'd1;
                end
            end
            PH_ACK: begin
                ack = 1'b1;
                if (fail_q) begin
                    cmd_fail  = 1'b1;
                    fail_nxt  = 1'b0;
                    phase_nxt = PH_IDLE;
                end else begin
                    phase_nxt = PH_DRAIN;
                    wd_nxt    = WD_LOAD;
                end
            end
            PH_DRAIN: begin
                if (!ready_all) begin
                    // Chaining straight into the next ISSUE keeps a command at 3 cycles.
                    cmd_done = 1'b1;
                    if (go) begin
                        phase_nxt = PH_ISSUE;
                        wd_nxt    = WD_LOAD;
                    end else begin
                        phase_nxt = PH_IDLE;
                    end
                end else if (wd == 8'd0) begin
                    phase_nxt = PH_ACK;
                    fail_nxt  = 1'b1;
                    timeout   = 1'b1;
                end else begin
                    wd_nxt = wd - 8'd1;
                end
            end
            default: phase_nxt = PH_IDLE;
        endcase
    end

endmodule

// File: rtl/cannon_sequencer.sv
// Scheduler for the N x N message_passer array running Cannon's multiply:
// load, clear accumulators, skew, then N multiply/rotate rounds.
// Ports:
//   CLK, reset_n     clock, synchronous active-low reset
//   start, abort     run control (start sampled only in IDLE; abort wins)
//   ready_all        combined ready from the enabled passers
//   cmd, cmd_valid   array command and its valid
//   image_to_shift   0 = shift A, 1 = shift B
//   ack              one-cycle acknowledge
//   row_en, col_en   per-row / per-column enables
//   s_zero           high during CLEAR
//   busy, done       run in progress / one-cycle completion pulse
//   error            sticky watchdog flag, cleared on accepted start
//   round            multiply rounds completed this run (saturates at N)
//
// state     | meaning
// SEQ_IDLE  | waiting for start
// SEQ_LOAD  | load A and B (all masks)
// SEQ_CLEAR | zero accumulators
// SEQ_SKEW  | skew step k: sub 0 = A left, sub 1 = B up, masked by k
// SEQ_ROUND | round r: sub 0 = multiply, sub 1 = A left, sub 2 = B up
// SEQ_DONE  | one-cycle done pulse
module cannon_sequencer
    import cannon_sequencer_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     ready_all,
    output logic [2:0]               cmd,
    output logic                     cmd_valid,
    output logic                     image_to_shift,
    output logic                     ack,
    output logic [N-1:0]             row_en,
    output logic [N-1:0]             col_en,
    output logic                     s_zero,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [$clog2(N+1)-1:0]   round
);

    localparam int KW = $clog2(N);
    localparam int RW = $clog2(N+1);
    localparam logic [KW-1:0] K_LAST    = KW'(N - 1);
    localparam logic [RW-1:0] ROUND_MAX = RW'(N);
    localparam logic [N-1:0]  ALL_ONES  = {N{1'b1}};

    seq_state_t    state, state_nxt;
    logic [KW-1:0] k, k_nxt;
    logic [KW-1:0] r, r_nxt;
    logic [1:0]    sub, sub_nxt;
    logic [RW-1:0] round_q, round_nxt;
    logic          error_q, error_nxt;
    logic          abort_pend, abort_nxt;
    logic [N-1:0]  skew_mask;
    logic          go;
    logic          hs_done, hs_fail, hs_timeout;

    cmd_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .go        (go),
        .abort     (abort),
        .ready_all (ready_all),
        .cmd_valid (cmd_valid),
        .ack       (ack),
        .cmd_done  (hs_done),
        .cmd_fail  (hs_fail),
        .timeout   (hs_timeout)
    );

    // Skew step k leaves the first k rows/columns untouched.
    always_comb begin
        skew_mask = '0;
        for (int i = 0; i < N; i++) begin
            skew_mask[i] = (i >= int'(k));
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state      <= SEQ_IDLE;
            k          <= '0;
            r          <= '0;
            sub        <= '0;
            round_q    <= '0;
            error_q    <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            r          <= r_nxt;
            sub        <= sub_nxt;
            round_q    <= round_nxt;
            error_q    <= error_nxt;
            abort_pend <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        k_nxt          = k;
        r_nxt          = r;
        sub_nxt        = sub;
        round_nxt      = round_q;
        error_nxt      = error_q | hs_timeout;
        abort_nxt      = abort_pend;
        go             = 1'b0;
        cmd            = CMD_MULT;
        image_to_shift = 1'b0;
        row_en         = '0;
        col_en         = '0;
        s_zero         = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        case (state)
            SEQ_IDLE: begin
                abort_nxt = 1'b0;
                if (start && !abort) begin
                    state_nxt = SEQ_LOAD;
                    k_nxt     = '0;
                    r_nxt     = '0;
                    sub_nxt   = '0;
                    round_nxt = '0;
                    error_nxt = 1'b0;
                    go        = 1'b1;
                end
            end
            SEQ_DONE: begin
                done      = 1'b1;
                state_nxt = SEQ_IDLE;
            end
            default: begin
                busy   = 1'b1;
                row_en = ALL_ONES;
                col_en = ALL_ONES;
                // Abort seen in ACK/DRAIN is held until the handshake closes.
                if (abort) abort_nxt = 1'b1;

                case (state)
                    SEQ_LOAD:  cmd = CMD_LOADAB;
                    SEQ_CLEAR: begin
                        cmd    = CMD_LOADS;
                        s_zero = 1'b1;
                    end
                    SEQ_SKEW: begin
                        if (sub == 2'd0) begin
                            cmd    = CMD_LEFT;
                            row_en = skew_mask;
                        end else begin
                            cmd            = CMD_UP;
                            image_to_shift = 1'b1;
                            col_en         = skew_mask;
                        end
                    end
                    SEQ_ROUND: begin
                        if (sub == 2'd1) begin
                            cmd = CMD_LEFT;
                        end else if (sub == 2'd2) begin
                            cmd            = CMD_UP;
                            image_to_shift = 1'b1;
                        end
                    end
                    default: ;
                endcase

                if (hs_fail) begin
                    state_nxt = SEQ_IDLE;
                end else if (hs_done) begin
                    case (state)
                        SEQ_LOAD:  state_nxt = SEQ_CLEAR;
                        SEQ_CLEAR: begin
                            state_nxt = SEQ_SKEW;
                            k_nxt     = KW'(1);
                            sub_nxt   = 2'd0;
                        end
                        SEQ_SKEW: begin
                            if (sub == 2'd0) begin
                                sub_nxt = 2'd1;
                            end else if (k == K_LAST) begin
                                state_nxt = SEQ_ROUND;
                                r_nxt     = '0;
                                sub_nxt   = 2'd0;
                            end else begin
                                k_nxt   = k + KW'(1);
                                sub_nxt = 2'd0;
                            end
                        end
                        SEQ_ROUND: begin
                            if (sub == 2'd0) begin
                                if (round_q != ROUND_MAX) round_nxt = round_q + RW'(1);
                                if (r == K_LAST) state_nxt = SEQ_DONE;
                                else             sub_nxt   = 2'd1;
                            end else if (sub == 2'd1) begin
                                sub_nxt = 2'd2;
                            end else begin
                                sub_nxt = 2'd0;
                                r_nxt   = r + KW'(1);
                            end
                        end
                        default: state_nxt = SEQ_IDLE;
                    endcase
                    if (abort || abort_pend) state_nxt = SEQ_IDLE;
                    go = (state_nxt != SEQ_IDLE) && (state_nxt != SEQ_DONE);
                end
            end
        endcase
    end

    assign round = round_q;
    assign error = error_q;

endmodule
